// File: rtl/mem_block_copier_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_copier_if
// Description : Control handshake and byte-wide memory port of the block copier.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_block_copier_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] bytes_left;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // master: the copier itself; slave: control logic plus memory
    modport master (
        input  start, src_addr, dst_addr, length, mem_rdata,
        output busy, done, bytes_left, mem_address, mem_read, mem_write, mem_wdata
    );

    modport slave (
        output start, src_addr, dst_addr, length, mem_rdata,
        input  busy, done, bytes_left, mem_address, mem_read, mem_write, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_block_copier.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_copier
// Description : Copies LENGTH bytes from src to dst, one read + one write per byte.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_block_copier #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                RST,
    mem_block_copier_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_zero = '0;
    localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W-1:0] r_bytes_left;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_nxt;
    logic [ADDR_W-1:0] w_left_nxt;
    logic [DATA_W-1:0] w_data_nxt;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_src_ptr    <= c_zero;
            r_dst_ptr    <= c_zero;
            r_bytes_left <= c_zero;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_src_ptr    <= w_src_nxt;
            r_dst_ptr    <= w_dst_nxt;
            r_bytes_left <= w_left_nxt;
            r_data       <= w_data_nxt;
        end
    end

    // Outputs decode only from registered state so they settle well before the memory's negedge.
    always_comb begin
        w_state_nxt     = r_state;
        w_src_nxt       = r_src_ptr;
        w_dst_nxt       = r_dst_ptr;
        w_left_nxt      = r_bytes_left;
        w_data_nxt      = r_data;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = c_zero;
        bus.mem_wdata   = '0;
        bus.bytes_left  = r_bytes_left;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.length != c_zero) begin
                        w_src_nxt   = bus.src_addr;
                        w_dst_nxt   = bus.dst_addr;
                        w_left_nxt  = bus.length;
                        w_state_nxt = S_RD;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_RD: begin
                bus.busy        = 1'b1;
                bus.mem_read    = 1'b1;
                bus.mem_address = r_src_ptr;
                w_data_nxt      = bus.mem_rdata;
                w_state_nxt     = S_WR;
            end
            S_WR: begin
                bus.busy        = 1'b1;
                bus.mem_write   = 1'b1;
                bus.mem_address = r_dst_ptr;
                bus.mem_wdata   = r_data;
                // Pointers wrap modulo 2^ADDR_W by plain truncation.
                w_src_nxt       = r_src_ptr + c_one;
                w_dst_nxt       = r_dst_ptr + c_one;
                w_left_nxt      = r_bytes_left - c_one;
                w_state_nxt     = (r_bytes_left == c_one) ? S_FIN : S_RD;
            end
            S_FIN: begin
                bus.done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
